// File: rtl/fifo_pkg.sv
// Shared definitions for the shift-FIFO drain side: read-controller state
// encoding, default word width and the FIFO depth.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH         = 4;

    // Read controller phases: waiting for a word, strobe high, strobe low
    // while the FIFO edge detector and pointer settle.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STROBE_H = 2'd1,
        GAP      = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_read_ctrl.sv
// Drain-side controller for the 4-entry shift FIFO.
//
// Handshake: out_data/out_valid form a valid/ready source. A word transfers
// on every rising clk edge where out_valid && out_ready. Once out_valid is
// high, out_data holds steady until that transfer. A new word may be captured
// on the same edge as a transfer, so back-to-back words have no bubble.
//
// A read is one capture of the head word followed by a STROBE_HIGH-cycle
// trig_read pulse and a GAP_CYCLES-cycle low gap. The FIFO flags are not
// trusted again until the gap has elapsed. Reset mid-read drops the strobe at
// once. A word the FIFO has already popped is then lost together with
// out_data; this is accepted behaviour.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int STROBE_HIGH = 2,
    parameter int GAP_CYCLES  = 3,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   trig_read,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] read_count
);

    localparam int TIMER_MAX   = (STROBE_HIGH > GAP_CYCLES) ? STROBE_HIGH : GAP_CYCLES;
    localparam int TIMER_WIDTH = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_WIDTH-1:0] STROBE_LOAD = TIMER_WIDTH'(STROBE_HIGH - 1);
    localparam logic [TIMER_WIDTH-1:0] GAP_LOAD    = TIMER_WIDTH'(GAP_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);

    rd_state_t              state;
    rd_state_t              state_nxt;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] timer_nxt;
    logic                   start_ok;
    logic                   capture;
    logic                   count_inc;

    // A read may start only when the output slot is free or being freed now.
    assign start_ok = en && !fifo_empty && (!out_valid || out_ready);

    // Strobe and busy are decoded from state so reset clears them immediately.
    assign trig_read = (state == STROBE_H);
    assign busy      = (state != IDLE);

    // Next-state, timer reload/decrement and per-read events.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        capture   = 1'b0;
        count_inc = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = STROBE_H;
                    timer_nxt = STROBE_LOAD;
                    capture   = 1'b1;
                end
            end
            STROBE_H: begin
                if (timer == '0) begin
                    state_nxt = GAP;
                    timer_nxt = GAP_LOAD;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            GAP: begin
                // Timer reaches zero on exit, so IDLE always sees a cleared timer.
                if (timer == '0) begin
                    state_nxt = IDLE;
                    count_inc = 1'b1;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // FSM state and strobe timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Completed-read counter; wraps naturally at 2^COUNT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_count <= '0;
        end else if (count_inc) begin
            read_count <= read_count + COUNT_WIDTH'(1);
        end
    end

    // Output register stage: capture wins over a same-edge transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= fifo_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: an environment FIFO that pops on each strobe
// rising edge, a cycle-number reference model, a word scoreboard, a vector
// table of directed scenarios, random traffic and hand-written corner cases.
module tb_fifo_read_ctrl;
    import fifo_pkg::*;

    localparam int DW     = 8;
    localparam int SH     = 2;
    localparam int GC     = 3;
    localparam int CW     = 8;
    localparam int PERIOD = 1 + SH + GC;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          trig_read;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic [CW-1:0] read_count;

    fifo_read_ctrl #(
        .DATA_WIDTH (DW),
        .STROBE_HIGH(SH),
        .GAP_CYCLES (GC),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .trig_read (trig_read),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .read_count(read_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] fifo_q[$];   // environment FIFO contents, head at [0]
    logic [DW-1:0] pend_q[$];   // words waiting for FIFO space
    logic [DW-1:0] exp_q[$];    // scoreboard: words expected downstream, in order
    bit            en_v;
    bit            rdy_v;
    bit            trig_prev;
    int            rise_cnt;

    // Reference model: a read started in cycle s strobes in cycles s+1..s+SH,
    // is busy through s+SH+GC and counts on edge s+PERIOD.
    int            cyc;
    int            m_s;
    bit            m_ov;
    logic [DW-1:0] m_od;
    logic [CW-1:0] m_cnt;

    typedef struct {
        int          n_words;
        logic [31:0] words;      // word k in bits [8k+7:8k]
        bit          en;
        bit          rdy;
        int          cycles;
        int          exp_rises;
        int          exp_reads;
        bit          exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t rows[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s   = cyc - 1000;
        m_ov  = 1'b0;
        m_od  = '0;
        m_cnt = '0;
        fifo_q.delete();
        pend_q.delete();
        exp_q.delete();
        trig_prev = 1'b0;
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic check_phase();
        int d;
        d = cyc - m_s;
        check("trig_read",  {31'd0, trig_read}, {31'd0, (d >= 1 && d <= SH)});
        check("busy",       {31'd0, busy},      {31'd0, (d >= 1 && d <= SH + GC)});
        check("out_valid",  {31'd0, out_valid}, {31'd0, m_ov});
        check("out_data",   {24'd0, out_data},  {24'd0, m_od});
        check("read_count", {24'd0, read_count}, {24'd0, m_cnt});
    endtask

    // Environment FIFO reaction, new inputs, scoreboard, model advance.
    task automatic drive_phase();
        bit            start;
        int            d;
        logic [DW-1:0] w;
        logic [31:0]   exp_w;
        if (trig_read && !trig_prev) begin
            rise_cnt++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        trig_prev = trig_read;
        while (pend_q.size() > 0 && fifo_q.size() < FIFO_DEPTH) begin
            w = pend_q.pop_front();
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        en         = en_v;
        out_ready  = rdy_v;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? DW'($urandom) : fifo_q[0];
        if (out_valid && out_ready) begin
            exp_w = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hFFFF_FFFF;
            check("sb_word", {24'd0, out_data}, exp_w);
        end
        d     = cyc - m_s;
        start = (d >= PERIOD) && en && !fifo_empty && (!m_ov || out_ready);
        if (cyc + 1 - m_s == PERIOD) m_cnt = m_cnt + 1'b1;
        if (start) begin
            m_od = fifo_data;
            m_ov = 1'b1;
            m_s  = cyc;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_phase();
        drive_phase();
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) pend_q.push_back(DW'($urandom));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          base_r;
        logic [CW-1:0] base_c;
        bit          seen;
        bit          found;

        rows[0] = '{n_words: 0, words: 32'h0,         en: 1'b1, rdy: 1'b1, cycles: 50,  exp_rises: 0, exp_reads: 0, exp_valid: 1'b0, exp_data: 8'h00};
        rows[1] = '{n_words: 4, words: 32'hD4C3B2A1,  en: 1'b1, rdy: 1'b1, cycles: 40,  exp_rises: 4, exp_reads: 4, exp_valid: 1'b0, exp_data: 8'hD4};
        rows[2] = '{n_words: 2, words: 32'h0000B2A1,  en: 1'b1, rdy: 1'b0, cycles: 100, exp_rises: 1, exp_reads: 1, exp_valid: 1'b1, exp_data: 8'hA1};
        rows[3] = '{n_words: 0, words: 32'h0,         en: 1'b1, rdy: 1'b1, cycles: 40,  exp_rises: 1, exp_reads: 1, exp_valid: 1'b0, exp_data: 8'hB2};
        rows[4] = '{n_words: 3, words: 32'h00332211,  en: 1'b0, rdy: 1'b1, cycles: 30,  exp_rises: 0, exp_reads: 0, exp_valid: 1'b0, exp_data: 8'hB2};
        rows[5] = '{n_words: 0, words: 32'h0,         en: 1'b1, rdy: 1'b1, cycles: 40,  exp_rises: 3, exp_reads: 3, exp_valid: 1'b0, exp_data: 8'h33};

        rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        en_v = 1'b0; rdy_v = 1'b0; rise_cnt = 0; cyc = 0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_trig",  {31'd0, trig_read}, 32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {24'd0, out_data},  32'd0);
        check("rst_count", {24'd0, read_count}, 32'd0);
        rst_n = 1'b1;
        drive_phase();

        // Directed scenario table.
        for (int r = 0; r < 6; r++) begin
            base_r = rise_cnt;
            base_c = read_count;
            for (int k = 0; k < rows[r].n_words; k++) pend_q.push_back(rows[r].words[8*k +: 8]);
            en_v  = rows[r].en;
            rdy_v = rows[r].rdy;
            repeat (rows[r].cycles) tick();
            check($sformatf("row%0d_rises", r), rise_cnt - base_r, rows[r].exp_rises);
            check($sformatf("row%0d_reads", r), {24'd0, CW'(read_count - base_c)}, rows[r].exp_reads);
            check($sformatf("row%0d_valid", r), {31'd0, out_valid}, {31'd0, rows[r].exp_valid});
            check($sformatf("row%0d_data", r),  {24'd0, out_data},  {24'd0, rows[r].exp_data});
        end
        check("table_fifo_drained", fifo_q.size(), 0);

        // Random traffic against the model and scoreboard.
        for (int i = 0; i < 600; i++) begin
            en_v  = ($urandom_range(0, 7) != 0);
            rdy_v = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) == 0 && pend_q.size() < 8) push_rand(1);
            tick();
        end
        en_v = 1'b1; rdy_v = 1'b1;
        repeat (120) tick();
        check("rand_exp_empty",  exp_q.size(),  0);
        check("rand_fifo_empty", fifo_q.size() + pend_q.size(), 0);

        // en dropped in the first GAP cycle with three words queued.
        base_r = rise_cnt; base_c = read_count; seen = 1'b0; found = 1'b0;
        push_rand(3);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            check_phase();
            if (seen && !trig_read) begin
                found = 1'b1;
                en_v  = 1'b0;
            end
            if (trig_read) seen = 1'b1;
            drive_phase();
        end
        check("endrop_gap_found", {31'd0, found}, 32'd1);
        repeat (30) tick();
        check("endrop_rises", rise_cnt - base_r, 1);
        check("endrop_reads", {24'd0, CW'(read_count - base_c)}, 1);
        check("endrop_left",  fifo_q.size(), 2);
        en_v = 1'b1;
        repeat (30) tick();
        check("endrop_rises_all", rise_cnt - base_r, 3);
        check("endrop_reads_all", {24'd0, CW'(read_count - base_c)}, 3);

        // Asynchronous reset in the middle of a strobe.
        seen = 1'b0;
        push_rand(2);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            check_phase();
            if (trig_read) seen = 1'b1;
            else drive_phase();
        end
        check("rst_mid_found", {31'd0, seen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_trig",  {31'd0, trig_read}, 32'd0);
        check("rst_mid_busy",  {31'd0, busy},      32'd0);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_count", {24'd0, read_count}, 32'd0);
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        en_v = 1'b1; rdy_v = 1'b1;
        drive_phase();
        repeat (5) tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // 255 reads, then one more wraps the counter.
        base_r = rise_cnt;
        push_rand(255);
        repeat (255 * PERIOD + 30) tick();
        check("wrap_255",   {24'd0, read_count}, 32'd255);
        check("wrap_rises", rise_cnt - base_r, 255);
        push_rand(1);
        repeat (20) tick();
        check("wrap_to_0",  {24'd0, read_count}, 32'd0);
        check("wrap_exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
